// File: rtl/retire_trace_buffer_pkg.sv
// Shared types for the retire trace buffer: datapath widths and the trace entry record.
package retire_trace_buffer_pkg;

  localparam int XLEN        = 32;
  localparam int SEQW        = 32;
  localparam int TRACE_DROPW = 16;

  typedef struct packed {
    logic [SEQW-1:0] seq;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      reg_addr;
    logic [XLEN-1:0] reg_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            mem_wrt;
  } trace_entry_t;

endpackage

// File: rtl/retire_trace_buffer_if.sv
// Retire bus from the core plus the valid/ready trace stream toward the sink.
interface retire_trace_buffer_if;
  import retire_trace_buffer_pkg::*;

  logic            update_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] instr_i;
  logic [4:0]      reg_addr_i;
  logic [XLEN-1:0] reg_data_i;
  logic [XLEN-1:0] mem_addr_i;
  logic [XLEN-1:0] mem_data_i;
  logic            mem_wrt_i;
  logic            trace_valid_o;
  logic            trace_ready_i;
  trace_entry_t    trace_entry_o;

  // master is the trace buffer itself; slave is the core/sink environment
  modport master (
    input  update_i, pc_i, instr_i, reg_addr_i, reg_data_i,
           mem_addr_i, mem_data_i, mem_wrt_i, trace_ready_i,
    output trace_valid_o, trace_entry_o
  );

  modport slave (
    output update_i, pc_i, instr_i, reg_addr_i, reg_data_i,
           mem_addr_i, mem_data_i, mem_wrt_i, trace_ready_i,
    input  trace_valid_o, trace_entry_o
  );

endinterface

// File: rtl/retire_trace_buffer_mem.sv
// Unreset register-array storage for the trace FIFO: one sync write port, one comb read port.
module trace_fifo_mem
  import retire_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  trace_entry_t             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output trace_entry_t             rdata
);

  trace_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/retire_trace_buffer.sv
// Captures retired instructions into a first-word-fall-through FIFO, tags them with a
// sequence number and reports drops when the sink cannot keep up.
module retire_trace_buffer
  import retire_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  retire_trace_buffer_if.master    bus,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [TRACE_DROPW-1:0]   drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [SEQW-1:0] seq;
  logic            cap, pop, push, drop, full, empty;
  trace_entry_t    wr_entry;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign cap  = bus.update_i & enable_i;
  assign pop  = bus.trace_valid_o & bus.trace_ready_i;
  // A full FIFO still accepts a retire when the head leaves in the same cycle
  assign push = cap & (~full | pop) & ~clear_i;
  assign drop = cap & full & ~pop;

  assign bus.trace_valid_o = ~empty;
  assign count_o           = wr_ptr - rd_ptr;

  assign wr_entry = '{seq:      seq,
                      pc:       bus.pc_i,
                      instr:    bus.instr_i,
                      reg_addr: bus.reg_addr_i,
                      reg_data: bus.reg_data_i,
                      mem_addr: bus.mem_addr_i,
                      mem_data: bus.mem_data_i,
                      mem_wrt:  bus.mem_wrt_i};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (clear_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + TRACE_DROPW'(1);
    end
  end

  // Every capture consumes a number, even when dropped or flushed, so gaps expose losses
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)  seq <= '0;
    else if (cap) seq <= seq + SEQW'(1);
  end

  trace_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk_i),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (bus.trace_entry_o)
  );

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Scoreboard bench for retire_trace_buffer: a queue-level model predicts occupancy and entries.
module tb_retire_trace_buffer;
  import retire_trace_buffer_pkg::*;

  localparam int DEPTH = 16;

  logic clk;
  logic rstn;
  logic enable;
  logic clear;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic [TRACE_DROPW-1:0]   drop_cnt;

  retire_trace_buffer_if bus ();

  retire_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .enable_i   (enable),
    .clear_i    (clear),
    .bus        (bus),
    .count_o    (count),
    .overflow_o (overflow),
    .drop_cnt_o (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           vectors    = 0;
  int           miscompares = 0;
  trace_entry_t exp_q [$];
  int           model_count = 0;
  bit           model_ovf   = 1'b0;
  int           model_drop  = 0;
  logic [SEQW-1:0] model_seq = '0;
  trace_entry_t payload;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkModel();
    checkOutput("count", 256'(count), 256'(model_count));
    checkOutput("valid", 256'(bus.trace_valid_o), 256'(model_count != 0));
    checkOutput("overflow", 256'(overflow), 256'(model_ovf));
    checkOutput("drop_cnt", 256'(drop_cnt), 256'(model_drop));
  endtask

  task automatic setPayload(input logic [XLEN-1:0] pc);
    payload.seq      = '0;
    payload.pc       = pc;
    payload.instr    = $urandom;
    payload.reg_addr = 5'($urandom);
    payload.reg_data = $urandom;
    payload.mem_addr = $urandom;
    payload.mem_data = $urandom;
    payload.mem_wrt  = 1'($urandom);
  endtask

  task automatic idleInputs();
    bus.update_i      = 1'b0;
    bus.trace_ready_i = 1'b0;
    clear             = 1'b0;
  endtask

  task automatic modelReset();
    exp_q.delete();
    model_count = 0;
    model_ovf   = 1'b0;
    model_drop  = 0;
    model_seq   = '0;
  endtask

  // Drive one cycle of inputs (called at posedge+1), then advance the model at the edge
  task automatic applyStimulus(input bit upd, input bit en, input bit clr, input bit rdy);
    bit cap, pop, full;
    trace_entry_t e;
    bus.update_i      = upd;
    enable            = en;
    clear             = clr;
    bus.trace_ready_i = rdy;
    bus.pc_i          = payload.pc;
    bus.instr_i       = payload.instr;
    bus.reg_addr_i    = payload.reg_addr;
    bus.reg_data_i    = payload.reg_data;
    bus.mem_addr_i    = payload.mem_addr;
    bus.mem_data_i    = payload.mem_data;
    bus.mem_wrt_i     = payload.mem_wrt;
    @(posedge clk);
    cap  = upd && en;
    pop  = rdy && (model_count > 0);
    full = (model_count == DEPTH);
    if (clr) begin
      exp_q.delete();
      model_count = 0;
      model_ovf   = 1'b0;
      model_drop  = 0;
    end else begin
      if (pop) model_count--;
      if (cap) begin
        if (!full || pop) begin
          e     = payload;
          e.seq = model_seq;
          exp_q.push_back(e);
          model_count++;
        end else begin
          model_ovf = 1'b1;
          if (model_drop < 16'hFFFF) model_drop++;
        end
      end
    end
    if (cap) model_seq = model_seq + 1;
    #1;
    checkModel();
  endtask

  task automatic retire(input logic [XLEN-1:0] pc, input bit rdy);
    setPayload(pc);
    applyStimulus(1'b1, 1'b1, 1'b0, rdy);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      setPayload($urandom);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    end
  endtask

  // Monitor: whenever the head is offered it must match the oldest expected entry
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && bus.trace_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_valid: actual entry %0h required no entry", bus.trace_entry_o);
        end else begin
          checkOutput("head_entry", 256'(bus.trace_entry_o), 256'(exp_q[0]));
          if (bus.trace_ready_i === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rstn   = 1'b0;
    enable = 1'b0;
    idleInputs();
    setPayload('0);
    bus.pc_i = '0; bus.instr_i = '0; bus.reg_addr_i = '0; bus.reg_data_i = '0;
    bus.mem_addr_i = '0; bus.mem_data_i = '0; bus.mem_wrt_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkModel();
    rstn = 1'b1;

    $display("[TB] three back-to-back retires with ready high");
    retire(32'h0, 1'b1);
    retire(32'h4, 1'b1);
    retire(32'h8, 1'b1);
    drain(3);

    $display("[TB] overflow with 20 retires into a stalled sink");
    for (int i = 0; i < 20; i++) retire(32'h1000 + 32'(i) * 4, 1'b0);
    drain(16);
    retire(32'h2000, 1'b1);
    drain(2);

    $display("[TB] full FIFO with simultaneous pop and push");
    for (int i = 0; i < DEPTH; i++) retire(32'h3000 + 32'(i) * 4, 1'b0);
    retire(32'h3100, 1'b1);
    drain(DEPTH + 1);

    $display("[TB] stall hold then clear alongside a retire");
    for (int i = 0; i < 8; i++) retire(32'h4000 + 32'(i) * 4, 1'b0);
    for (int i = 0; i < 10; i++) begin
      setPayload($urandom);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    end
    setPayload(32'h4100);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    retire(32'h4104, 1'b1);
    drain(2);

    $display("[TB] disabled capture then a store retire");
    for (int i = 0; i < 5; i++) begin
      setPayload(32'h5000 + 32'(i) * 4);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    end
    setPayload(32'h5100);
    payload.mem_wrt  = 1'b1;
    payload.mem_addr = 32'h100;
    payload.mem_data = 32'hDEADBEEF;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    drain(2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      setPayload($urandom);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
                    $urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0);
    end
    drain(DEPTH + 1);

    $display("[TB] asynchronous reset mid-stream");
    for (int i = 0; i < 6; i++) retire(32'h6000 + 32'(i) * 4, 1'b0);
    idleInputs();
    #3;
    rstn = 1'b0;
    #1;
    modelReset();
    checkOutput("async_rst_valid", 256'(bus.trace_valid_o), 256'(0));
    checkOutput("async_rst_count", 256'(count), 256'(0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    retire(32'h7000, 1'b1);
    drain(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/retire_trace_buffer.md
Name: retire_trace_buffer

Overview:
- Downstream consumer of the single-cycle core's retire interface (update/pc/instr/reg/mem retire signals).
- Captures each retired instruction into a FIFO, tags it with a sequence number and delivers it over a valid/ready stream to a trace sink (testbench scoreboard or debug UART).
- Decouples the one-retire-per-cycle core from a slower sink. Overflow is reported, never silent.

Parameters:
- XLEN, 32, datapath width (taken from riscv_pkg).
- DEPTH, 16, FIFO entries. Must be a power of two, at least 2.
- SEQW, 32, sequence-number width.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- enable_i  in  1  capture enable; retires are ignored while low
- clear_i  in  1  synchronous flush of FIFO, overflow flag and drop counter
- update_i  in  1  core retire strobe
- pc_i  in  XLEN  retired PC
- instr_i  in  XLEN  retired instruction
- reg_addr_i  in  5  retired rd address
- reg_data_i  in  XLEN  retired rd data
- mem_addr_i  in  XLEN  retired memory address
- mem_data_i  in  XLEN  retired memory data
- mem_wrt_i  in  1  retired store flag
- trace_valid_o  out  1  head entry available
- trace_ready_i  in  1  sink accepts head entry
- trace_entry_o  out  trace_entry_t  head entry {seq, pc, instr, reg_addr, reg_data, mem_addr, mem_data, mem_wrt}
- count_o  out  $clog2(DEPTH)+1  current occupancy
- overflow_o  out  1  sticky: at least one retire was dropped
- drop_cnt_o  out  16  dropped-retire count, saturating at 16'hFFFF

Behaviour:
- Reset (rstn_i low, asynchronous):
  - pointers, count_o, overflow_o, drop_cnt_o and the sequence counter all go to 0
  - trace_valid_o = 0
  - storage contents are don't-care
- Capture event (cap): update_i & enable_i, sampled on the rising edge of clk_i.
- Sequence counter:
  - Increments by 1 on every cap, whether the entry is stored or dropped, so drops show up as seq gaps.
  - Wraps modulo 2^SEQW.
  - The entry stored for a cap carries the counter value before the increment; the first entry after reset has seq = 0.
- Pop event (pop): trace_valid_o & trace_ready_i.
- Push rule: push = cap & (!full | pop). When full and popping in the same cycle, the push is accepted and occupancy stays at DEPTH.
- Drop rule:
  - drop = cap & full & !pop.
  - On drop: overflow_o is set, drop_cnt_o increments (saturating), and storage is unchanged.
- FIFO organisation:
  - First-word-fall-through: trace_valid_o = (count_o != 0).
  - trace_entry_o is driven combinationally from the head slot.
  - A pushed entry is visible at the output the cycle after the push edge. Write-to-read latency is 1 cycle; there is no same-cycle bypass.
  - Pointers are $clog2(DEPTH)+1 bits with natural wrap; full/empty are decided by the MSB compare.
  - count_o = wr_ptr - rd_ptr.
- Empty with ready high: no pop, and the head is don't-care.
- Stall rule: trace_entry_o must hold stable while trace_valid_o & !trace_ready_i.
- Simultaneous push and pop when not full and not empty: count is unchanged and both pointers advance.
- clear_i (synchronous, priority over push/pop in the same cycle):
  - pointers, count, overflow_o and drop_cnt_o go to 0
  - the sequence counter is NOT cleared
  - a cap in the same cycle is discarded but still increments seq
- enable_i low: update_i has no effect (no push, no seq increment); pops continue normally.
- Reset asserted mid-stream: all state clears immediately. Any entries in flight are lost; this is not flagged.

Decomposition:
- riscv_pkg additions:
  - trace_entry_t packed struct (field order as in the trace_entry_o port)
  - TRACE_DROPW = 16 localparam
- One sub-module, trace_fifo_mem:
  - DEPTH x $bits(trace_entry_t) register array
  - one synchronous write port, one combinational read port
  - no reset on the storage
- The top level holds pointers, counters, flags and handshake logic.

Test Plan:
- Reset, then 3 consecutive retires (pc 0x0, 0x4, 0x8) with ready=1 -> three outputs with seq 0, 1, 2 in order, each one cycle after capture; count_o returns to 0; overflow_o=0.
- Ready=0 and 20 back-to-back retires with DEPTH=16 -> count_o=16, overflow_o=1, drop_cnt_o=4. Then drain with ready=1 -> seq 0..15 delivered. The next retire gets seq 20.
- Full FIFO, ready=1 and a retire in the same cycle -> no drop, count_o stays 16, the new entry lands at the tail, drop_cnt_o unchanged.
- 8 entries held with ready=0 -> trace_entry_o stable over 10 cycles. Then clear_i for 1 cycle alongside a retire -> count_o=0, trace_valid_o=0, overflow_o=0, and the following retire carries seq incremented past the discarded one.
- enable_i=0 with 5 retires -> count_o=0 and seq unchanged. A store retire (mem_wrt_i=1, mem_addr 0x100, data 0xDEADBEEF) after enable -> delivered with those exact fields.
- Assert rstn_i asynchronously mid-cycle with 6 entries queued -> trace_valid_o, count_o and seq read 0 immediately, without waiting for a clock edge.
